// File: rtl/vga_console_pkg.sv
// ----------------------------------------------------------------------------
// vga_console_pkg
// Shared definitions for the text-mode console writer:
//   - default grid geometry (COLS_DEF x ROWS_DEF) and the fill byte
//   - control-code constants (BS, TAB, LF, FF, CR)
//   - FSM state encoding (TAB only exists when VGA_CONSOLE_TAB_EN is defined)
//   - is_printable() helper for the 0x20..0x7E range
// Optional feature macro: VGA_CONSOLE_TAB_EN
// ----------------------------------------------------------------------------
package vga_console_pkg;

    localparam int         COLS_DEF = 100;
    localparam int         ROWS_DEF = 37;
    localparam logic [7:0] FILL_DEF = 8'h20;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CLEAR_LINE   = 2'd1,
        CLEAR_SCREEN = 2'd2
`ifdef VGA_CONSOLE_TAB_EN
        ,
        TAB          = 2'd3
`endif
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_console_writer_if.sv
// ----------------------------------------------------------------------------
// vga_console_writer_if
// Byte-stream input handshake plus framebuffer write port and cursor status.
//   char_in/char_valid/char_ready : byte source -> writer (valid/ready)
//   busy                          : multi-cycle operation in progress
//   fb_data/fb_addr/fb_we         : framebuffer write port, one cell per cycle
//   cursor_col/cursor_row         : current cursor position
// Modports: master = byte source / framebuffer sink, slave = console writer.
// ----------------------------------------------------------------------------
interface vga_console_writer_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic              busy;
    logic [7:0]        fb_data;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_we;
    logic [6:0]        cursor_col;
    logic [5:0]        cursor_row;

    modport master (
        output char_in, char_valid,
        input  char_ready, busy, fb_data, fb_addr, fb_we, cursor_col, cursor_row
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, busy, fb_data, fb_addr, fb_we, cursor_col, cursor_row
    );
endinterface

// File: rtl/vga_console_cursor.sv
// ----------------------------------------------------------------------------
// vga_console_cursor
// Cursor tracker: column, row and row_base (= row*COLS, kept incrementally so
// no multiplier is needed).
// Ports:
//   clk50, rst          : clock, synchronous active-high reset
//   advance             : col+1, wrapping into a row advance at the last column
//   newline             : col=0 and row advance
//   back                : col-1 when col>0
//   cret                : col=0, row unchanged
//   home                : col=0, row=0
//   col, row            : current position (registered)
//   addr                : row_base + col, the cell under the cursor
//   wrap                : cursor sits in the last column (advance would wrap)
// Command priority: home > newline > advance > back > cret.
// ----------------------------------------------------------------------------
module vga_console_cursor #(
    parameter int COLS   = 100,
    parameter int ROWS   = 37,
    parameter int ADDR_W = 12
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              advance,
    input  logic              newline,
    input  logic              back,
    input  logic              cret,
    input  logic              home,
    output logic [6:0]        col,
    output logic [5:0]        row,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    logic [6:0]        col_q, col_d;
    logic [5:0]        row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              row_adv;

    assign wrap = (col_q == 7'(COLS - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise an
        // untaken branch would infer a latch.
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        row_adv = 1'b0;

        if (home) begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
        end else if (newline || (advance && wrap)) begin
            col_d   = '0;
            row_adv = 1'b1;
        end else if (advance) begin
            col_d = col_q + 7'd1;
        end else if (back && (col_q != '0)) begin
            col_d = col_q - 7'd1;
        end else if (cret) begin
            col_d = '0;
        end

        // Last row wraps straight back to the top; there is no scrolling.
        if (row_adv) begin
            if (row_q == 6'(ROWS - 1)) begin
                row_d  = '0;
                base_d = '0;
            end else begin
                row_d  = row_q + 6'd1;
                base_d = base_q + ADDR_W'(COLS);
            end
        end
    end

    always_ff @(posedge clk50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = base_q + ADDR_W'(col_q);

endmodule

// File: rtl/vga_console_writer.sv
// ----------------------------------------------------------------------------
// vga_console_writer
// Text-mode front end for the vga_controller framebuffer. Accepts bytes over a
// valid/ready handshake, writes printable bytes at the cursor and interprets
// CR, LF, BS and FF (plus TAB when VGA_CONSOLE_TAB_EN is defined). Row advances
// clear the new row; FF clears the whole screen.
// Ports:
//   clk50 : 50 MHz system clock
//   rst   : synchronous active-high reset; aborts any clear in progress
//   bus   : vga_console_writer_if.slave (byte handshake, framebuffer write
//           port, busy, cursor position); all outputs are registered
// Optional feature macro: VGA_CONSOLE_TAB_EN
// The interface ADDR_W parameter must match this module's ADDR_W.
// ----------------------------------------------------------------------------
module vga_console_writer
    import vga_console_pkg::*;
#(
    parameter int         COLS   = COLS_DEF,
    parameter int         ROWS   = ROWS_DEF,
    parameter int         ADDR_W = 12,
    parameter logic [7:0] FILL   = FILL_DEF
) (
    input  logic                 clk50,
    input  logic                 rst,
    vga_console_writer_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;
    logic              char_ready_q;
    logic              busy_q;

    logic              cur_advance, cur_newline, cur_back, cur_cret, cur_home;
    logic [6:0]        cur_col;
    logic [5:0]        cur_row;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_wrap;
    logic              accept;

    vga_console_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk50   (clk50),
        .rst     (rst),
        .advance (cur_advance),
        .newline (cur_newline),
        .back    (cur_back),
        .cret    (cur_cret),
        .home    (cur_home),
        .col     (cur_col),
        .row     (cur_row),
        .addr    (cur_addr),
        .wrap    (cur_wrap)
    );

    // char_ready_q is registered as (next state == IDLE), so it always equals
    // (state_q == IDLE) outside reset.
    assign accept = bus.char_valid && char_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        cur_advance = 1'b0;
        cur_newline = 1'b0;
        cur_back    = 1'b0;
        cur_cret    = 1'b0;
        cur_home    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(bus.char_in)) begin
                        // Write lands at the old cursor; the row advance (if
                        // any) and its line clear follow.
                        fb_we_d     = 1'b1;
                        fb_addr_d   = cur_addr;
                        fb_data_d   = bus.char_in;
                        cur_advance = 1'b1;
                        if (cur_wrap) begin
                            state_d = CLEAR_LINE;
                            cnt_d   = '0;
                        end
                    end else begin
                        case (bus.char_in)
                            CH_LF: begin
                                cur_newline = 1'b1;
                                state_d     = CLEAR_LINE;
                                cnt_d       = '0;
                            end
                            CH_CR: cur_cret = 1'b1;
                            CH_BS: begin
                                if (cur_col != '0) begin
                                    cur_back  = 1'b1;
                                    fb_we_d   = 1'b1;
                                    fb_addr_d = cur_addr - ADDR_W'(1);
                                    fb_data_d = FILL;
                                end
                            end
                            CH_FF: begin
                                cur_home = 1'b1;
                                state_d  = CLEAR_SCREEN;
                                cnt_d    = '0;
                            end
`ifdef VGA_CONSOLE_TAB_EN
                            CH_TAB: state_d = TAB;
`endif
                            default: ;
                        endcase
                    end
                end
            end

            // Cursor already sits at col 0 of the new row, so cur_addr is the
            // row base here.
            CLEAR_LINE: begin
                fb_we_d   = 1'b1;
                fb_addr_d = cur_addr + cnt_q;
                fb_data_d = FILL;
                if (cnt_q == ADDR_W'(COLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            CLEAR_SCREEN: begin
                fb_we_d   = 1'b1;
                fb_addr_d = cnt_q;
                fb_data_d = FILL;
                if (cnt_q == ADDR_W'(ROWS * COLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

`ifdef VGA_CONSOLE_TAB_EN
            // One FILL per cycle; stop once the next column is a multiple of 8
            // or the row wraps.
            TAB: begin
                fb_we_d     = 1'b1;
                fb_addr_d   = cur_addr;
                fb_data_d   = FILL;
                cur_advance = 1'b1;
                if (cur_wrap) begin
                    state_d = CLEAR_LINE;
                    cnt_d   = '0;
                end else if (cur_col[2:0] == 3'd7) begin
                    state_d = IDLE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            char_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            char_ready_q <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.char_ready = char_ready_q;
    assign bus.busy       = busy_q;
    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign bus.cursor_col = cur_col;
    assign bus.cursor_row = cur_row;

endmodule

// File: tb/tb_vga_console_writer.sv
// ----------------------------------------------------------------------------
// tb_vga_console_writer
// Self-checking bench for vga_console_writer. A behavioural cursor model
// pushes expected framebuffer writes into a queue when a byte is accepted; a
// monitor pops and compares every fb_we cycle on the falling edge.
// Optional feature macro: VGA_CONSOLE_TAB_EN (changes TAB expectations).
// ----------------------------------------------------------------------------
module tb_vga_console_writer;

    localparam int         COLS   = 100;
    localparam int         ROWS   = 37;
    localparam int         ADDR_W = 12;
    localparam logic [7:0] FILL   = 8'h20;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic clk50 = 1'b0;
    logic rst   = 1'b1;

    vga_console_writer_if #(.ADDR_W(ADDR_W)) bus ();

    vga_console_writer #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .FILL   (FILL)
    ) dut (
        .clk50 (clk50),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 clk50 = ~clk50;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_wr  = 0;
    wr_t exp_q[$];
    int  m_col = 0;
    int  m_row = 0;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk50) begin
        if (!rst && bus.fb_we) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL fb_write_unexpected: got addr=%0d data=%02h, required no write",
                         bus.fb_addr, bus.fb_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.fb_addr !== e.addr || bus.fb_data !== e.data) begin
                    n_bad++;
                    $display("FAIL fb_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             bus.fb_addr, bus.fb_data, e.addr, e.data);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic model_row_adv();
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        m_col = 0;
        for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, FILL);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(m_row * COLS + m_col, b);
            if (m_col == COLS - 1) model_row_adv();
            else m_col++;
        end else begin
            case (b)
                8'h0A: model_row_adv();
                8'h0D: m_col = 0;
                8'h08: if (m_col > 0) begin
                    m_col--;
                    push_wr(m_row * COLS + m_col, FILL);
                end
                8'h0C: begin
                    m_col = 0;
                    m_row = 0;
                    for (int i = 0; i < ROWS * COLS; i++) push_wr(i, FILL);
                end
`ifdef VGA_CONSOLE_TAB_EN
                8'h09: begin
                    bit done;
                    done = 1'b0;
                    while (!done) begin
                        push_wr(m_row * COLS + m_col, FILL);
                        if (m_col == COLS - 1) begin
                            model_row_adv();
                            done = 1'b1;
                        end else begin
                            m_col++;
                            if (m_col % 8 == 0) done = 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Presents a byte from a falling edge, holds it until char_ready, and
    // returns #1 after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk50);
        bus.char_in    = b;
        bus.char_valid = 1'b1;
        while (!bus.char_ready && t < 20000) begin
            @(negedge clk50);
            t++;
        end
        n_cmp++;
        if (!bus.char_ready) begin
            n_bad++;
            $display("FAIL accept_timeout: byte %02h not accepted after %0d cycles", b, t);
        end
        model_byte(b);
        @(posedge clk50);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 10000) begin
            @(negedge clk50);
            t++;
        end
        @(negedge clk50);
        n_cmp++;
        if (exp_q.size() != 0 || bus.busy) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d writes still pending, busy=%0b", exp_q.size(), bus.busy);
        end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        n_cmp++;
        if (bus.cursor_col !== 7'(col) || bus.cursor_row !== 6'(row)) begin
            n_bad++;
            $display("FAIL %s: got cursor col=%0d row=%0d, required col=%0d row=%0d",
                     name, bus.cursor_col, bus.cursor_row, col, row);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk50);
        n_cmp++;
        if (bus.char_ready !== 1'b0 || bus.busy !== 1'b0 || bus.fb_we !== 1'b0 ||
            bus.fb_addr !== '0 || bus.fb_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%0b busy=%0b we=%0b addr=%0d data=%02h, required 0 0 0 0 00",
                     bus.char_ready, bus.busy, bus.fb_we, bus.fb_addr, bus.fb_data);
        end
        check_cursor("reset_cursor", 0, 0);
        rst = 1'b0;
        @(posedge clk50);
        #1;
        n_cmp++;
        if (bus.char_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got ready=%0b busy=%0b, required 1 0", bus.char_ready, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h41);
        n_cmp++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 12'd0 || bus.fb_data !== 8'h41) begin
            n_bad++;
            $display("FAIL b2b_first: got we=%0b addr=%0d data=%02h, required 1 0 41",
                     bus.fb_we, bus.fb_addr, bus.fb_data);
        end
        send_byte(8'h42);
        n_cmp++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 12'd1 || bus.fb_data !== 8'h42) begin
            n_bad++;
            $display("FAIL b2b_second: got we=%0b addr=%0d data=%02h, required 1 1 42",
                     bus.fb_we, bus.fb_addr, bus.fb_data);
        end
        drain();
        check_cursor("b2b_cursor", 2, 0);
    endtask

    task automatic test_crlf();
        send_byte(8'h0D);
        send_byte(8'h0A);
        @(negedge clk50);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.char_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_line_flags: got busy=%0b ready=%0b, required 1 0", bus.busy, bus.char_ready);
        end
        send_byte(8'h58);
        drain();
        check_cursor("crlf_cursor", 1, 1);
    endtask

    task automatic test_backspace();
        int w0;
        send_byte(8'h0D);
        send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
        send_byte(8'h08);
        drain();
        check_cursor("bs_cursor", 4, 2);
        send_byte(8'h0D);
        drain();
        w0 = n_wr;
        send_byte(8'h08);
        repeat (5) @(negedge clk50);
        n_cmp++;
        if (n_wr != w0) begin
            n_bad++;
            $display("FAIL bs_col0_nowrite: got %0d writes, required 0", n_wr - w0);
        end
        check_cursor("bs_col0_cursor", 0, 2);
    endtask

    task automatic test_tab();
        int w0;
        for (int i = 0; i < 3; i++) send_byte(8'h70 + 8'(i));
        drain();
        w0 = n_wr;
        send_byte(8'h09);
        drain();
        n_cmp++;
`ifdef VGA_CONSOLE_TAB_EN
        if (n_wr - w0 != 5) begin
            n_bad++;
            $display("FAIL tab_writes: got %0d writes, required 5", n_wr - w0);
        end
        check_cursor("tab_cursor", 8, 2);
`else
        if (n_wr != w0) begin
            n_bad++;
            $display("FAIL tab_writes: got %0d writes, required 0", n_wr - w0);
        end
        check_cursor("tab_cursor", 3, 2);
`endif
    endtask

    task automatic test_wrap();
        send_byte(8'h0C);
        drain();
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send_byte(8'h30 + 8'(i % 10));
        drain();
        check_cursor("wrap_pre_cursor", COLS - 1, ROWS - 1);
        send_byte(8'h5A);
        n_cmp++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 12'd3699 || bus.fb_data !== 8'h5A) begin
            n_bad++;
            $display("FAIL wrap_last_cell: got we=%0b addr=%0d data=%02h, required 1 3699 5a",
                     bus.fb_we, bus.fb_addr, bus.fb_data);
        end
        drain();
        check_cursor("wrap_post_cursor", 0, 0);
    endtask

    task automatic test_ff_reset();
        int w0;
        int t;
        send_byte(8'h41);
        drain();
        w0 = n_wr;
        send_byte(8'h0C);
        t = 0;
        while (n_wr - w0 < 1000 && t < 5000) begin
            @(negedge clk50);
            #1;
            t++;
        end
        n_cmp++;
        if (n_wr - w0 != 1000) begin
            n_bad++;
            $display("FAIL ff_progress: got %0d writes, required 1000", n_wr - w0);
        end
        rst = 1'b1;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        repeat (3) @(negedge clk50);
        rst = 1'b0;
        repeat (50) @(negedge clk50);
        n_cmp++;
        if (n_wr - w0 != 1000 || bus.fb_we !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ff_abort: got %0d writes we=%0b busy=%0b, required 1000 0 0",
                     n_wr - w0, bus.fb_we, bus.busy);
        end
        check_cursor("ff_abort_cursor", 0, 0);
    endtask

    initial begin
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_crlf();
        test_backspace();
        test_tab();
        test_wrap();
        test_ff_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_console_writer.md
Name: vga_console_writer

Overview:
- Text-mode front end that drives the framebuffer write port (fb_data/fb_addr/fb_we) of vga_controller.
- Accepts a byte stream from the CPU/UART side over a valid/ready handshake and turns it into per-cell framebuffer writes.
- Maintains a cursor and interprets control codes: CR, LF, BS, FF.
- Grid is 100x37 cells, which is 800x600 with an 8x16 font. Cell address = row*COLS + col, which fits in 12 bits.

Parameters:
- COLS, 100, characters per row
- ROWS, 37, rows per screen
- ADDR_W, 12, framebuffer address width
- FILL, 8'h20, byte written for cleared/erased cells

Ports:
- clk50  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- char_in  in  8  input byte
- char_valid  in  1  char_in valid
- char_ready  out  1  block can accept a byte this cycle
- busy  out  1  multi-cycle operation (clear line/screen, tab) in progress
- fb_data  out  8  framebuffer write data
- fb_addr  out  ADDR_W  framebuffer write address
- fb_we  out  1  framebuffer write strobe, one cycle per cell
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  6  current row, 0..ROWS-1

Behaviour:
- Clock and reset: one clock, clk50. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; cursor 0,0; row_base 0; fb_we 0; fb_addr 0; fb_data 0; busy 0; char_ready 0 during reset, 1 in the first cycle after.
- Registered outputs: all outputs are registered.
- Address generation: row_base register, incremented by COLS on row advance and reset to 0 on wrap; no multiplier. fb_addr = row_base + col.
- Handshake: a byte is accepted when char_valid && char_ready. char_ready = (state == IDLE). busy = (state != IDLE).
- Latency: the write for an accepted byte appears with fb_we=1 on the next cycle. Back-to-back printable bytes sustain 1 per cycle while no row change occurs.
- Printable bytes (0x20..0x7E):
  - write the byte at the cursor, then col+1.
  - if col was COLS-1: col=0, row advance.
- LF (0x0A): col=0, row advance.
- CR (0x0D): col=0; no write.
- BS (0x08):
  - if col>0: col-1, then write FILL at the new position.
  - if col==0: no-op; no write, no row change.
- FF (0x0C): enter CLEAR_SCREEN, cursor goes to 0,0.
- All other bytes: accepted and discarded; no write.
- Row advance:
  - row+1; if row was ROWS-1, row=0 (wrap, no scroll).
  - then enter CLEAR_LINE for the new row.
- CLEAR_LINE: COLS consecutive fb_we cycles writing FILL to row_base+0 .. row_base+COLS-1, then IDLE. Cursor is already at the new row, col 0.
- CLEAR_SCREEN: ROWS*COLS (3700) consecutive writes of FILL to addresses 0..3699, then IDLE.
- Input during CLEAR_LINE/CLEAR_SCREEN: char_ready=0; bytes are held off, never dropped.
- Address bound: fb_addr never exceeds ROWS*COLS-1.
- Reset mid-operation: rst during any clear aborts it immediately. Outputs go to reset values and no further writes are issued.
- Simultaneous events: a printable byte at col COLS-1 performs its write first, then the row advance and CLEAR_LINE.

Optional Feature:
- Macro: VGA_CONSOLE_TAB_EN.
- With macro, TAB (0x09):
  - enters state TAB and writes FILL at successive cells until col is a multiple of 8, always at least 1 write. busy=1 meanwhile.
  - if col reaches COLS, applies the normal wrap: col=0, row advance, CLEAR_LINE.
- Without macro: 0x09 is discarded like any other non-printable byte, and state TAB does not exist.

Decomposition:
- Package vga_console_pkg holds:
  - COLS, ROWS, FILL defaults.
  - control-code constants: CH_BS, CH_TAB, CH_LF, CH_FF, CH_CR.
  - state encoding: IDLE, CLEAR_LINE, CLEAR_SCREEN, TAB.
- One sub-module, vga_console_cursor, tracks col/row/row_base.
  - inputs: advance, newline, back, home.
  - outputs: col, row, addr, wrap flag.
- Top level holds the FSM and fb port registers.

Test Plan:
- Reset, then send 'A','B' on consecutive cycles -> fb_we on 2 consecutive cycles: addr 0 data 0x41, then addr 1 data 0x42; cursor_col=2.
- Send CR LF, then 'X' -> after LF, 100 writes of 0x20 to addrs 100..199 with busy=1 and char_ready=0; then 'X' written at addr 100.
- Cursor at row 36 col 99, send 'Z' -> write addr 3699 data 0x5A; row wraps to 0; 100 FILL writes to addrs 0..99; cursor 0,0.
- Cursor at col 5 row 2, send BS -> single write addr 204 data 0x20; cursor_col=4. Send BS at col 0 -> no fb_we.
- Send FF -> exactly 3700 fb_we cycles, addrs 0..3699 ascending, all data 0x20. Assert rst at write 1000 -> no fb_we afterwards; cursor 0,0.
- With VGA_CONSOLE_TAB_EN, col 3 send 0x09 -> 5 writes of 0x20 at cols 3..7, cursor_col=8. Without the macro -> no write, cursor_col stays 3.
